// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write arbiter: state encoding,
// the hardwired-zero register address and default widths.
package regfile_write_arbiter_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [2:0] REG_ZERO = 3'b000;

endpackage

// File: rtl/regfile_write_arbiter_sel.sv
// Source select for the write port: picks {addr, data} from requester 0 or 1
// according to the winner of the current arbitration.
module rf_arb_sel #(
    parameter int DATA_W = 16
) (
    input  logic              sel,
    input  logic [2:0]        addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic [2:0]        addr1,
    input  logic [DATA_W-1:0] data1,
    output logic [2:0]        addr,
    output logic [DATA_W-1:0] data
);

    assign {addr, data} = sel ? {addr1, data1} : {addr0, data0};

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter with a one-cycle bubble per grant.
// Define RF_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: r0 wins).
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int CNT_W  = RF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [2:0]        addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [2:0]        addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              mux_sel,
    output logic              wr_en,
    output logic [2:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [CNT_W-1:0]  conflict_cnt
);

    state_t            state;
    logic              cand0, cand1, take0, take1, tie_r1, denied;
    logic [2:0]        sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifdef RF_ARB_ROUND_ROBIN_EN
    logic last_r1;

    // On a tie the requester that did not win last time goes first.
    assign tie_r1 = ~last_r1;

    always_ff @(posedge clk) begin
        if (rst)
            last_r1 <= 1'b1;
        else if (take0 || take1)
            last_r1 <= take1;
    end
`else
    assign tie_r1 = 1'b0;
`endif

    // A requester just captured is ineligible for one edge so a held request
    // is not written twice.
    always_comb begin
        cand0  = req0 && (state != GNT0);
        cand1  = req1 && (state != GNT1);
        take1  = cand1 && (!cand0 || tie_r1);
        take0  = cand0 && !take1;
        denied = (req0 && !take0) || (req1 && !take1);
    end

    rf_arb_sel #(.DATA_W(DATA_W)) u_sel (
        .sel   (take1),
        .addr0 (addr0),
        .data0 (data0),
        .addr1 (addr1),
        .data1 (data1),
        .addr  (sel_addr),
        .data  (sel_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gnt0         <= 1'b0;
            gnt1         <= 1'b0;
            wr_en        <= 1'b0;
            mux_sel      <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            conflict_cnt <= '0;
        end else begin
            gnt0  <= take0;
            gnt1  <= take1;
            wr_en <= (take0 || take1) && (sel_addr != REG_ZERO);
            if (take0)
                state <= GNT0;
            else if (take1)
                state <= GNT1;
            else
                state <= IDLE;
            if (take0 || take1) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
                mux_sel <= take1;
            end
            if (denied && (conflict_cnt != {CNT_W{1'b1}}))
                conflict_cnt <= conflict_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, then random traffic
// against a request-level model. A second instance with CNT_W=2 covers saturation.
module tb_regfile_write_arbiter;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst, req0, req1;
    logic [2:0]    addr0, addr1;
    logic [DW-1:0] data0, data1;

    logic          gnt0, gnt1, mux_sel, wr_en;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [7:0]    conflict_cnt;

    logic          s_gnt0, s_gnt1, s_mux_sel, s_wr_en;
    logic [2:0]    s_wr_addr;
    logic [DW-1:0] s_wr_data;
    logic [1:0]    s_conflict_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(DW), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .mux_sel(mux_sel), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .conflict_cnt(conflict_cnt)
    );

    regfile_write_arbiter #(.DATA_W(DW), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .gnt0(s_gnt0), .gnt1(s_gnt1), .mux_sel(s_mux_sel), .wr_en(s_wr_en),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .conflict_cnt(s_conflict_cnt)
    );

    typedef struct {
        logic        rst, r0;
        logic [2:0]  a0;
        logic [15:0] d0;
        logic        r1;
        logic [2:0]  a1;
        logic [15:0] d1;
        logic        g0, g1, we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        ms;
        int          cnt, cnt2;
    } vec_t;

    vec_t tbl[20];

    // Request-level model: who was written last edge, who won the last tie.
    int          m_last_cap;   // 0 none, 1 r0, 2 r1
    int          m_last_win;   // last requester granted (0 or 1)
    logic        m_g0, m_g1, m_we, m_ms;
    logic [2:0]  m_wa;
    logic [15:0] m_wd;
    int          m_cnt, m_cnt2;

    function automatic vec_t mk(input logic rs, r0, input logic [2:0] a0, input logic [15:0] d0,
                                input logic r1, input logic [2:0] a1, input logic [15:0] d1,
                                input logic g0, g1, we, input logic [2:0] wa,
                                input logic [15:0] wd, input logic ms, input int c, c2);
        vec_t v;
        v.rst = rs; v.r0 = r0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.we = we; v.wa = wa; v.wd = wd; v.ms = ms;
        v.cnt = c; v.cnt2 = c2;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        int win;
        bit e0, e1, deny;
        if (rst) begin
            m_last_cap = 0; m_last_win = 1;
            m_g0 = 0; m_g1 = 0; m_we = 0; m_ms = 0; m_wa = 0; m_wd = 0;
            m_cnt = 0; m_cnt2 = 0;
            return;
        end
        e0 = req0 && (m_last_cap != 1);
        e1 = req1 && (m_last_cap != 2);
        win = -1;
        if (e0 && e1) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            win = 1 - m_last_win;
`else
            win = 0;
`endif
        end else if (e0) win = 0;
        else if (e1) win = 1;
        deny = (req0 && win != 0) || (req1 && win != 1);
        if (deny) begin
            m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
            m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
        end
        m_g0 = (win == 0);
        m_g1 = (win == 1);
        if (win >= 0) begin
            m_wa = (win == 0) ? addr0 : addr1;
            m_wd = (win == 0) ? data0 : data1;
            m_ms = (win == 1);
            m_we = (m_wa != 3'd0);
            m_last_win = win;
            m_last_cap = win + 1;
        end else begin
            m_we = 0;
            m_last_cap = 0;
        end
    endtask

    task automatic check_all(input string tag, input logic g0, g1, we, input logic [2:0] wa,
                             input logic [15:0] wd, input logic ms, input int c, c2);
        check({tag, ".gnt0"},    32'(gnt0),    32'(g0));
        check({tag, ".gnt1"},    32'(gnt1),    32'(g1));
        check({tag, ".wr_en"},   32'(wr_en),   32'(we));
        check({tag, ".wr_addr"}, 32'(wr_addr), 32'(wa));
        check({tag, ".wr_data"}, 32'(wr_data), 32'(wd));
        check({tag, ".mux_sel"}, 32'(mux_sel), 32'(ms));
        check({tag, ".cnt"},     32'(conflict_cnt),   c);
        check({tag, ".cnt2"},    32'(s_conflict_cnt), c2);
    endtask

    initial begin
        // reset with both requesting, then r0 wins the first tie
        tbl[0]  = mk(1, 1,3'd1,16'h1111, 1,3'd2,16'h2222, 0,0,0,3'd0,16'h0000,0, 0,0);
        tbl[1]  = mk(1, 1,3'd1,16'h1111, 1,3'd2,16'h2222, 0,0,0,3'd0,16'h0000,0, 0,0);
        tbl[2]  = mk(0, 1,3'd1,16'h1111, 1,3'd2,16'h2222, 1,0,1,3'd1,16'h1111,0, 1,1);
        tbl[3]  = mk(0, 0,3'd1,16'h1111, 1,3'd2,16'h2222, 0,1,1,3'd2,16'h2222,1, 1,1);
        tbl[4]  = mk(0, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 0,0,0,3'd2,16'h2222,1, 1,1);
        // single request, held one extra cycle: no duplicate write
        tbl[5]  = mk(0, 1,3'd3,16'h00AB, 0,3'd0,16'h0000, 1,0,1,3'd3,16'h00AB,0, 1,1);
        tbl[6]  = mk(0, 1,3'd3,16'h00AB, 0,3'd0,16'h0000, 0,0,0,3'd3,16'h00AB,0, 2,2);
        tbl[7]  = mk(0, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 0,0,0,3'd3,16'h00AB,0, 2,2);
        // contention: each side has three writes, r0 drops after its last grant
        tbl[8]  = mk(1, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 0,0,0,3'd0,16'h0000,0, 0,0);
        tbl[9]  = mk(0, 1,3'd4,16'h4000, 1,3'd5,16'h5000, 1,0,1,3'd4,16'h4000,0, 1,1);
        tbl[10] = mk(0, 1,3'd4,16'h4001, 1,3'd5,16'h5000, 0,1,1,3'd5,16'h5000,1, 2,2);
        tbl[11] = mk(0, 1,3'd4,16'h4001, 1,3'd5,16'h5001, 1,0,1,3'd4,16'h4001,0, 3,3);
        tbl[12] = mk(0, 1,3'd4,16'h4002, 1,3'd5,16'h5001, 0,1,1,3'd5,16'h5001,1, 4,3);
        tbl[13] = mk(0, 1,3'd4,16'h4002, 1,3'd5,16'h5002, 1,0,1,3'd4,16'h4002,0, 5,3);
        tbl[14] = mk(0, 0,3'd0,16'h0000, 1,3'd5,16'h5002, 0,1,1,3'd5,16'h5002,1, 5,3);
        tbl[15] = mk(0, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 0,0,0,3'd5,16'h5002,1, 5,3);
        // write to R0: grant without write enable, then reset while in GNT1
        tbl[16] = mk(0, 0,3'd0,16'h0000, 1,3'd0,16'hBEEF, 0,1,0,3'd0,16'hBEEF,1, 5,3);
        tbl[17] = mk(1, 0,3'd0,16'h0000, 1,3'd0,16'hBEEF, 0,0,0,3'd0,16'h0000,0, 0,0);
        tbl[18] = mk(0, 0,3'd0,16'h0000, 1,3'd6,16'h6666, 0,1,1,3'd6,16'h6666,1, 0,0);
        tbl[19] = mk(0, 0,3'd0,16'h0000, 0,3'd0,16'h0000, 0,0,0,3'd6,16'h6666,1, 0,0);

        rst = 1; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst; req0 = tbl[i].r0; addr0 = tbl[i].a0; data0 = tbl[i].d0;
            req1 = tbl[i].r1; addr1 = tbl[i].a1; data1 = tbl[i].d1;
            model_step();
            @(posedge clk); #1;
            check_all($sformatf("vec%0d", i), tbl[i].g0, tbl[i].g1, tbl[i].we, tbl[i].wa,
                      tbl[i].wd, tbl[i].ms, tbl[i].cnt, tbl[i].cnt2);
        end

        rst = 1; req0 = 0; req1 = 0;
        model_step();
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 24) == 0);
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            addr0 = 3'($urandom_range(0, 7));
            addr1 = 3'($urandom_range(0, 7));
            data0 = 16'($urandom);
            data1 = 16'($urandom);
            model_step();
            @(posedge clk); #1;
            check_all($sformatf("rnd%0d", i), m_g0, m_g1, m_we, m_wa, m_wd, m_ms, m_cnt, m_cnt2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
